uart_work_rx: RTL and testbench

UART_WORK_RX -- requirements
Module: uart_work_rx

---
 rtl/uart_work_rx.sv | 160 ++++++++++++++++
 tb/tb_uart_work_rx.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/uart_work_rx.sv
// 8N1 UART receiver that assembles 84-byte work frames into data1/data2/data3/target.
// Optional idle timeout on a partial frame: define UART_WORK_RX_TIMEOUT_EN.
module uart_work_rx #(
  parameter int unsigned CLKS_PER_BIT = 217,
  parameter int unsigned TIMEOUT_CLKS = 2500000
) (
  input  logic         hash_clk,
  input  logic         reset,
  input  logic         rxd,
  output logic [255:0] data1,
  output logic [255:0] data2,
  output logic [127:0] data3,
  output logic [31:0]  target,
  output logic         loadnonce,
  output logic         rx_busy,
  output logic         frame_err
);

  if (CLKS_PER_BIT < 4 || CLKS_PER_BIT > 65535 || TIMEOUT_CLKS == 0) begin : g_param_chk
    $error("uart_work_rx: illegal parameter value");
  end

  localparam logic [15:0] FULL = 16'(CLKS_PER_BIT);
  localparam logic [15:0] HALF = 16'(CLKS_PER_BIT / 2);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t         state_q, state_d;
  logic           rxd_meta_q, rxd_q;
  logic [15:0]    cnt_q, cnt_d;
  logic [2:0]     bit_q, bit_d;
  logic [7:0]     shreg_q, shreg_d;
  logic [6:0]     byte_cnt_q, byte_cnt_d;
  // Holds the first 83 bytes; the 84th comes straight from the shifter.
  logic [663:0]   frame_q, frame_d;
  logic [671:0]   out_q, out_d;
  logic           loadnonce_q, loadnonce_d;
  logic           frame_err_q, frame_err_d;
  logic           tick;
  logic           timeout;

  assign tick = (cnt_q == 16'd1);

`ifdef UART_WORK_RX_TIMEOUT_EN
  logic [31:0] to_q, to_d;
  logic        to_arm;
  assign to_arm  = (byte_cnt_q != 7'd0) && (state_q == IDLE);
  assign timeout = to_arm && (to_q == 32'(TIMEOUT_CLKS - 1));
  always_comb to_d = to_arm ? to_q + 32'd1 : 32'd0;
  always_ff @(posedge hash_clk) begin
    if (reset) to_q <= 32'd0;
    else       to_q <= to_d;
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    shreg_d     = shreg_q;
    byte_cnt_d  = byte_cnt_q;
    frame_d     = frame_q;
    out_d       = out_q;
    loadnonce_d = 1'b0;
    frame_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rxd_q) begin
          state_d = START;
          cnt_d   = HALF;
        end
      end
      START: begin
        if (!tick) cnt_d = cnt_q - 16'd1;
        else if (!rxd_q) begin
          state_d = DATA;
          cnt_d   = FULL;
          bit_d   = 3'd0;
        end else begin
          state_d = IDLE;
          cnt_d   = 16'd0;
        end
      end
      DATA: begin
        if (!tick) cnt_d = cnt_q - 16'd1;
        else begin
          shreg_d = {rxd_q, shreg_q[7:1]};
          cnt_d   = FULL;
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (!tick) cnt_d = cnt_q - 16'd1;
        else begin
          state_d = IDLE;
          cnt_d   = 16'd0;
          if (rxd_q) begin
            frame_d = {frame_q[655:0], shreg_q};
            if (byte_cnt_q == 7'd83) begin
              out_d       = {frame_q, shreg_q};
              byte_cnt_d  = 7'd0;
              loadnonce_d = 1'b1;
            end else begin
              byte_cnt_d = byte_cnt_q + 7'd1;
            end
          end else begin
            byte_cnt_d  = 7'd0;
            frame_err_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // Timeout only arms in IDLE, so it cannot coincide with a byte acceptance.
    if (timeout) begin
      byte_cnt_d  = 7'd0;
      frame_err_d = 1'b1;
    end
  end

  always_ff @(posedge hash_clk) begin
    if (reset) begin
      state_q     <= IDLE;
      rxd_meta_q  <= 1'b1;
      rxd_q       <= 1'b1;
      cnt_q       <= 16'd0;
      bit_q       <= 3'd0;
      shreg_q     <= 8'd0;
      byte_cnt_q  <= 7'd0;
      frame_q     <= '0;
      out_q       <= {640'd0, 32'h0000_07ff};
      loadnonce_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rxd_meta_q  <= rxd;
      rxd_q       <= rxd_meta_q;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shreg_q     <= shreg_d;
      byte_cnt_q  <= byte_cnt_d;
      frame_q     <= frame_d;
      out_q       <= out_d;
      loadnonce_q <= loadnonce_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign data1     = out_q[671:416];
  assign data2     = out_q[415:160];
  assign data3     = out_q[159:32];
  assign target    = out_q[31:0];
  assign loadnonce = loadnonce_q;
  assign frame_err = frame_err_q;
  assign rx_busy   = (byte_cnt_q != 7'd0);

endmodule

// File: tb/tb_uart_work_rx.sv
// Directed/randomized bench for uart_work_rx; a byte-queue model predicts frames, pulses and busy.
module tb_uart_work_rx;
  localparam int CPB = 4;
  localparam int TO  = 200;
  localparam logic [671:0] RST_OUT = {640'd0, 32'h0000_07ff};

  logic         hash_clk = 1'b0;
  logic         reset, rxd;
  logic [255:0] data1, data2;
  logic [127:0] data3;
  logic [31:0]  target;
  logic         loadnonce, rx_busy, frame_err;

  uart_work_rx #(.CLKS_PER_BIT(CPB), .TIMEOUT_CLKS(TO)) dut (
    .hash_clk(hash_clk), .reset(reset), .rxd(rxd),
    .data1(data1), .data2(data2), .data3(data3), .target(target),
    .loadnonce(loadnonce), .rx_busy(rx_busy), .frame_err(frame_err)
  );

  always #5 hash_clk = ~hash_clk;

  int npass = 0, ntot = 0;
  int cyc = 0, ln_cnt = 0, fe_cnt = 0, both_cnt = 0;
  int ln_cyc[$];
  always @(posedge hash_clk) cyc <= cyc + 1;
  always @(negedge hash_clk) begin
    if (loadnonce) begin ln_cnt++; ln_cyc.push_back(cyc); end
    if (frame_err) fe_cnt++;
    if (loadnonce && frame_err) both_cnt++;
  end

  // Reference model: bytes of the frame in progress, in arrival order.
  logic [7:0]   q[$];
  logic [671:0] exp_out = RST_OUT;
  int           exp_ln = 0, exp_fe = 0;

  task automatic chk(input string tag, input logic [671:0] obs, input logic [671:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic chk_all(input string tag);
    chk({tag, "_out"}, {data1, data2, data3, target}, exp_out);
    chk({tag, "_busy"}, 672'(rx_busy), 672'(q.size() != 0));
    chk({tag, "_ln"}, 672'(ln_cnt), 672'(exp_ln));
    chk({tag, "_fe"}, 672'(fe_cnt), 672'(exp_fe));
  endtask

  task automatic wait_cyc(input int n);
    if (n > 0) begin
      repeat (n) @(posedge hash_clk);
      #1;
    end
  endtask

  task automatic model_byte(input logic [7:0] b);
    q.push_back(b);
    if (q.size() == 84) begin
      for (int i = 0; i < 84; i++) exp_out[671-8*i -: 8] = q[i];
      q.delete();
      exp_ln++;
    end
  endtask

  // A bad stop bit is held low only long enough to be sampled, so the line is
  // high again before the receiver re-examines it.
  task automatic send_byte(input logic [7:0] b, input bit ok, input int gap);
    rxd = 1'b0; wait_cyc(CPB);
    for (int i = 0; i < 8; i++) begin rxd = b[i]; wait_cyc(CPB); end
    if (ok) begin
      rxd = 1'b1; wait_cyc(CPB);
      model_byte(b);
    end else begin
      rxd = 1'b0; wait_cyc(CPB - 1);
      rxd = 1'b1; wait_cyc(1);
      q.delete();
      exp_fe++;
    end
    wait_cyc(gap);
  endtask

  task automatic send_rand(input int n, input int maxgap);
    for (int i = 0; i < n; i++) send_byte(8'($urandom), 1'b1, int'($urandom_range(maxgap, 0)));
  endtask

  initial begin
    int base;
    reset = 1'b1; rxd = 1'b1;
    wait_cyc(4);
    reset = 1'b0;
    wait_cyc(2);
    chk_all("reset");
    chk("reset_ln_sig", 672'(loadnonce), 672'(0));
    chk("reset_fe_sig", 672'(frame_err), 672'(0));

    // Counting frame
    for (int i = 0; i < 84; i++) send_byte(8'(i), 1'b1, 0);
    wait_cyc(3);
    chk_all("count");
    chk("count_d1_top", 672'(data1[255:248]), 672'(8'h00));
    chk("count_nonce", 672'(data3[127:96]), 672'(32'h40414243));
    chk("count_target", 672'(target), 672'(32'h50515253));

    // Framing error on the 10th byte, then a good frame
    send_rand(9, 2);
    send_byte(8'($urandom), 1'b0, 8);
    chk_all("ferr");
    send_rand(84, 3);
    wait_cyc(3);
    chk_all("after_ferr");

    // One-cycle glitch on the idle line
    rxd = 1'b0; wait_cyc(1);
    rxd = 1'b1; wait_cyc(20);
    chk_all("glitch");

    // Reset in the middle of byte 50
    send_rand(50, 1);
    rxd = 1'b0; wait_cyc(CPB);
    rxd = 1'b1; wait_cyc(CPB);
    rxd = 1'b0; wait_cyc(2);
    reset = 1'b1; rxd = 1'b1;
    wait_cyc(3);
    reset = 1'b0;
    q.delete();
    exp_out = RST_OUT;
    wait_cyc(5);
    chk_all("midreset");
    chk("midreset_target", 672'(target), 672'(32'h000007ff));
    send_rand(84, 2);
    wait_cyc(3);
    chk_all("after_reset");

    // Long idle in a partial frame
    send_rand(30, 0);
    wait_cyc(TO + 1);
`ifdef UART_WORK_RX_TIMEOUT_EN
    q.delete();
    exp_fe++;
    chk_all("timeout");
    send_rand(84, 1);
`else
    chk_all("no_timeout");
    send_rand(54, 1);
`endif
    wait_cyc(3);
    chk_all("timeout_done");

    // Back-to-back frames
    base = ln_cyc.size();
    send_rand(84, 0);
    send_rand(84, 0);
    wait_cyc(3);
    chk_all("b2b");
    if (ln_cyc.size() >= base + 2)
      chk("b2b_spacing", 672'(ln_cyc[base+1] - ln_cyc[base]), 672'(84 * 10 * CPB));
    else
      chk("b2b_pulses", 672'(ln_cyc.size()), 672'(base + 2));

    chk("ln_fe_overlap", 672'(both_cnt), 672'(0));

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
